supercar_scanner: RTL and testbench

- Downstream consumer of the edge-trigger pulses. Drives an N-LED "Knight Rider" light bar.
- Takes one-cycle command pulses from the push-button edge-trigger stages: speed up, speed down and mode toggle.
- Moves a single lit LED back and forth (bounce) or around (wrap) at a user-selectable step rate.

---
 rtl/supercar_scanner.sv | 156 +++++++++++++++
 tb/tb_supercar_scanner.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/supercar_scanner.sv
// Knight Rider light bar: one lit LED that bounces or wraps at a selectable step rate.
// Optional TRAIL_EN macro also lights the LED at the position held before the last step.
module supercar_scanner #(
  parameter int N_LEDS    = 8,
  parameter int TICK_DIV  = 1000000,
  parameter int SPEED_MAX = 3,
  localparam int PW = $clog2(N_LEDS),
  localparam int SW = (SPEED_MAX > 0) ? $clog2(SPEED_MAX + 1) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              speed_up_i,
  input  logic              speed_dn_i,
  input  logic              mode_tgl_i,
  output logic [N_LEDS-1:0] leds_o,
  output logic [PW-1:0]     pos_o,
  output logic              dir_o,
  output logic [SW-1:0]     speed_o,
  output logic              mode_o,
  output logic              step_o
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST     = PW'(N_LEDS - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(N_LEDS - 2);
  localparam logic [SW-1:0] SMAX     = SW'(SPEED_MAX);
  localparam logic [DW-1:0] DMAX     = DW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  state_t          state_q;
  logic [PW-1:0]   pos_q;
  logic            dir_q;
  logic            mode_q;
  logic            step_q;
  logic [SW-1:0]   speed_q, speed_d;
  logic [SW-1:0]   tick_cnt_q;
  logic [DW-1:0]   div_cnt_q;
`ifdef TRAIL_EN
  logic [PW-1:0]   prev_pos_q;
`endif

  logic tick, step_now;

  assign tick     = (state_q != IDLE) && (div_cnt_q == DMAX);
  // Threshold uses the live speed, so a change lands on the next tick without restarting.
  assign step_now = tick && (tick_cnt_q >= (SMAX - speed_q));

  always_comb begin
    speed_d = speed_q;
    if (speed_up_i && !speed_dn_i && (speed_q != SMAX))
      speed_d = speed_q + SW'(1);
    else if (speed_dn_i && !speed_up_i && (speed_q != '0))
      speed_d = speed_q - SW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      speed_q    <= '0;
      mode_q     <= 1'b0;
      step_q     <= 1'b0;
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
`ifdef TRAIL_EN
      prev_pos_q <= '0;
`endif
    end else begin
      speed_q <= speed_d;
      mode_q  <= mode_q ^ mode_tgl_i;
      step_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          pos_q      <= '0;
          dir_q      <= 1'b0;
          div_cnt_q  <= '0;
          tick_cnt_q <= '0;
`ifdef TRAIL_EN
          prev_pos_q <= '0;
`endif
          if (en_i) state_q <= LEFT;
        end
        LEFT, RIGHT: begin
          if (!en_i) begin
            // Dropping enable discards any step due this cycle.
            state_q    <= IDLE;
            pos_q      <= '0;
            dir_q      <= 1'b0;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
`ifdef TRAIL_EN
            prev_pos_q <= '0;
`endif
          end else begin
            div_cnt_q <= tick ? '0 : div_cnt_q + DW'(1);
            if (step_now) begin
              tick_cnt_q <= '0;
              step_q     <= 1'b1;
`ifdef TRAIL_EN
              prev_pos_q <= pos_q;
`endif
              if (state_q == LEFT) begin
                if (pos_q == LAST) begin
                  if (mode_q) begin
                    pos_q <= '0;
                  end else begin
                    state_q <= RIGHT;
                    dir_q   <= 1'b1;
                    pos_q   <= PRE_LAST;
                  end
                end else begin
                  pos_q <= pos_q + PW'(1);
                end
              end else begin
                if (pos_q == '0) begin
                  if (mode_q) begin
                    pos_q <= LAST;
                  end else begin
                    state_q <= LEFT;
                    dir_q   <= 1'b0;
                    pos_q   <= PW'(1);
                  end
                end else begin
                  pos_q <= pos_q - PW'(1);
                end
              end
            end else if (tick) begin
              tick_cnt_q <= tick_cnt_q + SW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    leds_o = '0;
    if (state_q != IDLE) begin
      leds_o = N_LEDS'(1) << pos_q;
`ifdef TRAIL_EN
      leds_o = leds_o | (N_LEDS'(1) << prev_pos_q);
`endif
    end
  end

  assign pos_o   = pos_q;
  assign dir_o   = dir_q;
  assign speed_o = speed_q;
  assign mode_o  = mode_q;
  assign step_o  = step_q;

endmodule

// File: tb/tb_supercar_scanner.sv
// Bench for supercar_scanner (N_LEDS=4, TICK_DIV=4, SPEED_MAX=3): command table plus a step scoreboard.
module tb_supercar_scanner;

  logic       clk = 1'b0;
  logic       rst, en, up, dn, tgl;
  logic [3:0] leds;
  logic [1:0] pos;
  logic       dir;
  logic [1:0] speed;
  logic       mode, step;

  always #5 clk = ~clk;

  supercar_scanner #(.N_LEDS(4), .TICK_DIV(4), .SPEED_MAX(3)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .speed_up_i(up), .speed_dn_i(dn),
    .mode_tgl_i(tgl), .leds_o(leds), .pos_o(pos), .dir_o(dir),
    .speed_o(speed), .mode_o(mode), .step_o(step)
  );

  typedef struct {
    int   pos;
    int   prev;
    logic dir;
    int   gap;
  } step_t;

  typedef struct {
    logic up;
    logic dn;
    logic tgl;
    int   spd;
    logic md;
  } vec_t;

  step_t sb[$];
  vec_t  vt[13];
  int n_tests = 0, n_fail = 0, cyc_n = 0, last_cyc = 0, exp_prev = 0;

  function automatic int exp_leds(int p, int pp);
    logic [3:0] v;
    v = 4'(1) << p;
`ifdef TRAIL_EN
    v = v | (4'(1) << pp);
`endif
    return int'(v);
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc_n);
    end
  endtask

  task automatic push(input int p, input logic d, input int gap);
    step_t e;
    e.pos = p; e.prev = exp_prev; e.dir = d; e.gap = gap;
    sb.push_back(e);
    exp_prev = p;
  endtask

  // One clock; outputs sampled on the falling edge, step pulses scored here.
  task automatic cyc();
    step_t e;
    @(negedge clk);
    cyc_n++;
    if (step) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_step: got step=1 at pos %0d, required no step (cycle %0d)", pos, cyc_n);
      end else begin
        e = sb.pop_front();
        chk("step_leds", int'(leds), exp_leds(e.pos, e.prev));
        chk("step_pos", int'(pos), e.pos);
        chk("step_dir", int'(dir), int'(e.dir));
        chk("step_gap", cyc_n - last_cyc, e.gap);
        last_cyc = cyc_n;
      end
    end
  endtask

  task automatic run_until_empty(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      cyc();
      k++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL step_timeout: got %0d steps pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_leds"}, int'(leds), 0);
    chk({nm, "_pos"}, int'(pos), 0);
    chk({nm, "_dir"}, int'(dir), 0);
    chk({nm, "_step"}, int'(step), 0);
  endtask

  task automatic enter();
    cyc();
    chk("entry_leds", int'(leds), 1);
    chk("entry_pos", int'(pos), 0);
    chk("entry_dir", int'(dir), 0);
    chk("entry_step", int'(step), 0);
    last_cyc = cyc_n;
    exp_prev = 0;
  endtask

  task automatic apply_vec(input int i);
    up = vt[i].up; dn = vt[i].dn; tgl = vt[i].tgl;
    cyc();
    up = 1'b0; dn = 1'b0; tgl = 1'b0;
    chk($sformatf("vec%0d_speed", i), int'(speed), vt[i].spd);
    chk($sformatf("vec%0d_mode", i), int'(mode), int'(vt[i].md));
    chk($sformatf("vec%0d_leds", i), int'(leds), 0);
  endtask

  initial begin
    // Commands applied while idle; mode is already wrap (1) when the table starts.
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 2, 1'b1};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 3, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 3, 1'b1};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 3, 1'b1};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 2, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 1, 1'b1};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 0, 1'b1};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 0, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b1, 0, 1'b1};
    vt[11] = '{1'b1, 1'b0, 1'b0, 1, 1'b1};
    vt[12] = '{1'b1, 1'b0, 1'b0, 2, 1'b1};

    rst = 1'b1; en = 1'b0; up = 1'b0; dn = 1'b0; tgl = 1'b0;
    cyc(); cyc();
    check_idle("reset");
    chk("reset_speed", int'(speed), 0);
    chk("reset_mode", int'(mode), 0);
    rst = 1'b0;
    cyc();
    check_idle("idle_en0");

    // Bounce at speed 0: 16-cycle period.
    en = 1'b1;
    enter();
    push(1, 1'b0, 16); push(2, 1'b0, 16); push(3, 1'b0, 16);
    push(2, 1'b1, 16); push(1, 1'b1, 16); push(0, 1'b1, 16); push(1, 1'b0, 16);
    run_until_empty(200);

    // Switch to wrap at pos 2 moving up.
    push(2, 1'b0, 16);
    run_until_empty(40);
    tgl = 1'b1;
    cyc();
    tgl = 1'b0;
    chk("tgl_mode", int'(mode), 1);
    push(3, 1'b0, 16); push(0, 1'b0, 16); push(1, 1'b0, 16); push(2, 1'b0, 16);
    run_until_empty(120);

    // Drop enable at pos 2, idle for a while, then restart with a full period.
    en = 1'b0;
    cyc();
    check_idle("drop_en");
    repeat (20) cyc();
    check_idle("idle_hold");
    en = 1'b1;
    enter();
    push(1, 1'b0, 16);
    run_until_empty(40);
    en = 1'b0;
    cyc();
    check_idle("drop_en2");

    // Speed up to saturation while idle, then run at the 4-cycle period.
    for (int i = 0; i < 5; i++) apply_vec(i);
    en = 1'b1;
    enter();
    push(1, 1'b0, 4); push(2, 1'b0, 4); push(3, 1'b0, 4); push(0, 1'b0, 4);
    run_until_empty(40);
    en = 1'b0;
    cyc();
    check_idle("drop_en3");

    // Speed down to saturation, mode toggles, then speed 2.
    for (int i = 5; i < 13; i++) apply_vec(i);
    en = 1'b1;
    enter();
    push(1, 1'b0, 8); push(2, 1'b0, 8); push(3, 1'b0, 8);
    run_until_empty(60);
    chk("pre_rst_speed", int'(speed), 2);
    chk("pre_rst_mode", int'(mode), 1);
    chk("pre_rst_pos", int'(pos), 3);

    // Reset mid-run wins over enable.
    rst = 1'b1;
    cyc();
    check_idle("mid_rst");
    chk("mid_rst_speed", int'(speed), 0);
    chk("mid_rst_mode", int'(mode), 0);
    rst = 1'b0;
    enter();
    push(1, 1'b0, 16);
    run_until_empty(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
